// File: rtl/spi_byte_receiver.sv
// spi_byte_receiver: oversampled SPI mode-0 slave producing bytes with a held rdy pulse.
// Optional MISO echo of the previous byte when SPI_MISO_ECHO_EN is defined.
module spi_byte_receiver #(
   parameter int RDY_HOLD       = 4,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       cs_n,
   output logic       miso,
   output logic [7:0] rx_byte,
   output logic       rdy,
   output logic       frame_err
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t      state, state_nx;
   logic [1:0]  sclk_sy, mosi_sy, cs_sy;
   logic        sclk_prev, rise, fall, cs_hi, mosi_s, done, err_nx;
   logic [6:0]  shift, shift_nx;
   logic [2:0]  bit_cnt, bit_cnt_nx;
   logic [15:0] idle_cnt;
   logic [3:0]  rdy_cnt;
   assign rise   = sclk_sy[1] & ~sclk_prev;
   assign fall   = ~sclk_sy[1] & sclk_prev;
   assign cs_hi  = cs_sy[1];
   assign mosi_s = mosi_sy[1];
   assign rdy    = rdy_cnt != 4'd0;
   always_comb begin
      state_nx   = state;
      shift_nx   = shift;
      bit_cnt_nx = bit_cnt;
      done       = 1'b0;
      err_nx     = 1'b0;
      if (state == IDLE) begin
         shift_nx   = '0;
         bit_cnt_nx = '0;
         state_nx   = cs_hi ? IDLE : ACTIVE;
      end else begin
         if (rise) begin
            shift_nx   = {shift[5:0], mosi_s};
            bit_cnt_nx = bit_cnt + 3'd1;
            done       = bit_cnt == 3'd7;
         end else if (idle_cnt == TIMEOUT_CYCLES[15:0] && bit_cnt != 3'd0) begin
            shift_nx   = '0;
            bit_cnt_nx = '0;
            err_nx     = 1'b1;
         end
         // a byte completing on the same cycle as CS release is not an abort
         if (cs_hi) begin
            err_nx     = err_nx | (bit_cnt_nx != 3'd0);
            shift_nx   = '0;
            bit_cnt_nx = '0;
            state_nx   = IDLE;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         sclk_sy   <= 2'b00;
         mosi_sy   <= 2'b00;
         cs_sy     <= 2'b11;
         sclk_prev <= 1'b0;
         state     <= IDLE;
         shift     <= '0;
         bit_cnt   <= '0;
         idle_cnt  <= '0;
         rdy_cnt   <= '0;
         rx_byte   <= '0;
         frame_err <= 1'b0;
      end else begin
         sclk_sy   <= {sclk_sy[0], sclk};
         mosi_sy   <= {mosi_sy[0], mosi};
         cs_sy     <= {cs_sy[0], cs_n};
         sclk_prev <= sclk_sy[1];
         state     <= state_nx;
         shift     <= shift_nx;
         bit_cnt   <= bit_cnt_nx;
         frame_err <= err_nx;
         idle_cnt  <= (state == IDLE || rise || fall) ? 16'd0 : (idle_cnt == 16'hffff ? idle_cnt : idle_cnt + 16'd1);
         rdy_cnt   <= done ? RDY_HOLD[3:0] : (rdy ? rdy_cnt - 4'd1 : 4'd0);
         if (done) rx_byte <= {shift, mosi_s};
      end
   end
`ifdef SPI_MISO_ECHO_EN
   logic [7:0] tx;
   // the fall right after a completed byte is skipped so bit 7 survives to the next first rise
   always_ff @(posedge clk) begin
      if (!reset) tx <= '0;
      else if (done) tx <= {shift, mosi_s};
      else if (state == IDLE && !cs_hi) tx <= rx_byte;
      else if (state == ACTIVE && fall && bit_cnt != 3'd0) tx <= {tx[6:0], 1'b0};
   end
   assign miso = (state == ACTIVE) & tx[7];
`else
   assign miso = 1'b0;
`endif
endmodule

// File: tb/tb_spi_byte_receiver.sv
// tb_spi_byte_receiver: randomized SPI frames checked against a bit-count byte model.
module tb_spi_byte_receiver;
   localparam int RDY_HOLD = 4;
   localparam int TMO      = 1023;
   logic       clk = 0, reset = 0, sclk = 0, mosi = 0, cs_n = 1;
   logic       miso, rdy, frame_err;
   logic [7:0] rx_byte;
   int         compared = 0, mismatched = 0;
   int         H = 4;
   logic [7:0] exp_last = 8'h00;
   always #5 clk = ~clk;
   spi_byte_receiver #(.RDY_HOLD(RDY_HOLD), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .miso(miso), .rx_byte(rx_byte), .rdy(rdy), .frame_err(frame_err)
   );
   logic [7:0] got_b[$];
   int         got_w[$];
   int         err_cnt = 0, err_long = 0, stab_viol = 0, wcnt = 0;
   logic       rdy_q = 0, err_q = 0;
   logic [7:0] byte_q = 0;
   always @(negedge clk) begin
      if (rdy && !rdy_q) got_b.push_back(rx_byte);
      if (!rdy && rdy_q) got_w.push_back(wcnt);
      if (rdy && rdy_q && rx_byte !== byte_q) stab_viol <= stab_viol + 1;
      wcnt <= rdy ? (rdy_q ? wcnt + 1 : 1) : 0;
      if (frame_err) err_cnt <= err_cnt + 1;
      if (frame_err && err_q) err_long <= err_long + 1;
      rdy_q  <= rdy;
      err_q  <= frame_err;
      byte_q <= rx_byte;
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic send_bit(input logic b, output logic m);
      mosi = b;
      cyc(H);
      m = miso;
      sclk = 1;
      cyc(H);
      sclk = 0;
   endtask
   task automatic send_byte(input logic [7:0] v, output logic [7:0] m);
      logic t;
      for (int i = 7; i >= 0; i--) begin
         send_bit(v[i], t);
         m[i] = t;
      end
      exp_last = v;
   endtask
   task automatic cs_lo();
      cs_n = 0;
      cyc(4);
   endtask
   task automatic cs_up();
      cyc(2);
      cs_n = 1;
      cyc(RDY_HOLD + 10);
   endtask
   task automatic test_reset();
      logic [7:0] m;
      logic       t;
      int         n0;
      reset = 0;
      cyc(3);
      compared += 4;
      if (rx_byte !== 8'h00) begin mismatched++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
      if (rdy !== 1'b0) begin mismatched++; $display("FAIL reset_rdy: got %b want 0", rdy); end
      if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      if (miso !== 1'b0) begin mismatched++; $display("FAIL reset_miso: got %b want 0", miso); end
      reset = 1;
      cyc(4);
      cs_lo();
      send_byte(8'h5A | 8'($urandom_range(1, 255)), m);
      for (int i = 0; i < 3; i++) send_bit(1'($urandom), t);
      mosi = 1'($urandom);
      cyc(H);
      sclk = 1;
      cyc(2);
      reset = 0;
      cyc(1);
      compared += 4;
      if (rx_byte !== 8'h00) begin mismatched++; $display("FAIL midreset_rx_byte: got %h want 00", rx_byte); end
      if (rdy !== 1'b0) begin mismatched++; $display("FAIL midreset_rdy: got %b want 0", rdy); end
      if (frame_err !== 1'b0) begin mismatched++; $display("FAIL midreset_frame_err: got %b want 0", frame_err); end
      if (miso !== 1'b0) begin mismatched++; $display("FAIL midreset_miso: got %b want 0", miso); end
      reset = 1;
      exp_last = 8'h00;
      cyc(H);
      sclk = 0;
      cyc(H);
      cs_up();
      n0 = got_b.size();
      cs_lo();
      send_byte(8'hA5, m);
      cs_up();
      compared += 2;
      if (got_b.size() != n0 + 1) begin mismatched++; $display("FAIL after_reset_count: got %0d want %0d", got_b.size() - n0, 1); end
      else if (got_b[n0] !== 8'hA5) begin mismatched++; $display("FAIL after_reset_byte: got %h want a5", got_b[n0]); end
      if (rx_byte !== 8'hA5) begin mismatched++; $display("FAIL after_reset_rx_byte: got %h want a5", rx_byte); end
   endtask
   task automatic test_stream();
      logic [7:0] v[5];
      logic [7:0] m;
      int         n0, w0, e0, s0;
      v[0] = 8'h55; v[1] = 8'h80; v[2] = 8'h11;
      v[3] = 8'($urandom); v[4] = 8'($urandom);
      n0 = got_b.size(); w0 = got_w.size(); e0 = err_cnt; s0 = stab_viol;
      cs_lo();
      for (int i = 0; i < 5; i++) send_byte(v[i], m);
      cs_up();
      compared++;
      if (got_b.size() != n0 + 5 || got_w.size() != w0 + 5) begin
         mismatched++; $display("FAIL stream_count: got %0d bytes %0d pulses want 5", got_b.size() - n0, got_w.size() - w0);
      end else begin
         for (int i = 0; i < 5; i++) begin
            compared += 2;
            if (got_b[n0 + i] !== v[i]) begin mismatched++; $display("FAIL stream_byte%0d: got %h want %h", i, got_b[n0 + i], v[i]); end
            if (got_w[w0 + i] != RDY_HOLD) begin mismatched++; $display("FAIL stream_width%0d: got %0d want %0d", i, got_w[w0 + i], RDY_HOLD); end
         end
      end
      compared += 3;
      if (stab_viol != s0) begin mismatched++; $display("FAIL stream_stable: got %0d changes want 0", stab_viol - s0); end
      if (err_cnt != e0) begin mismatched++; $display("FAIL stream_err: got %0d want 0", err_cnt - e0); end
      if (rx_byte !== v[4]) begin mismatched++; $display("FAIL stream_hold: got %h want %h", rx_byte, v[4]); end
   endtask
   task automatic test_cs_abort();
      logic [7:0] m;
      logic       t;
      int         n0, e0, l0;
      n0 = got_b.size(); e0 = err_cnt; l0 = err_long;
      cs_lo();
      for (int i = 0; i < 5; i++) send_bit(1'b1, t);
      cs_up();
      compared += 4;
      if (err_cnt != e0 + 1) begin mismatched++; $display("FAIL abort_err: got %0d want 1", err_cnt - e0); end
      if (err_long != l0) begin mismatched++; $display("FAIL abort_err_width: got %0d long want 0", err_long - l0); end
      if (got_b.size() != n0) begin mismatched++; $display("FAIL abort_rdy: got %0d pulses want 0", got_b.size() - n0); end
      if (rx_byte !== exp_last) begin mismatched++; $display("FAIL abort_rx_byte: got %h want %h", rx_byte, exp_last); end
      cs_lo();
      send_byte(8'h3C, m);
      cs_up();
      compared += 2;
      if (got_b.size() != n0 + 1) begin mismatched++; $display("FAIL abort_next_count: got %0d want 1", got_b.size() - n0); end
      else if (got_b[n0] !== 8'h3C) begin mismatched++; $display("FAIL abort_next_byte: got %h want 3c", got_b[n0]); end
      if (err_cnt != e0 + 1) begin mismatched++; $display("FAIL abort_next_err: got %0d want 1", err_cnt - e0); end
   endtask
   task automatic test_timeout();
      logic [7:0] m;
      logic       t;
      int         n0, e0;
      n0 = got_b.size(); e0 = err_cnt;
      cs_lo();
      for (int i = 0; i < 3; i++) send_bit(1'($urandom), t);
      cyc(TMO - 100);
      compared++;
      if (err_cnt != e0) begin mismatched++; $display("FAIL timeout_early: got %0d want 0", err_cnt - e0); end
      cyc(200);
      compared++;
      if (err_cnt != e0 + 1) begin mismatched++; $display("FAIL timeout_err: got %0d want 1", err_cnt - e0); end
      send_byte(8'hC3, m);
      cs_up();
      compared += 3;
      if (got_b.size() != n0 + 1) begin mismatched++; $display("FAIL timeout_count: got %0d want 1", got_b.size() - n0); end
      else if (got_b[n0] !== 8'hC3) begin mismatched++; $display("FAIL timeout_byte: got %h want c3", got_b[n0]); end
      if (rx_byte !== 8'hC3) begin mismatched++; $display("FAIL timeout_rx_byte: got %h want c3", rx_byte); end
      if (err_cnt != e0 + 1) begin mismatched++; $display("FAIL timeout_after_err: got %0d want 1", err_cnt - e0); end
   endtask
   task automatic test_simul();
      logic [7:0] v;
      logic       t;
      int         n0, e0;
      v = 8'($urandom);
      n0 = got_b.size(); e0 = err_cnt;
      cs_lo();
      for (int i = 7; i > 0; i--) send_bit(v[i], t);
      mosi = v[0];
      cyc(H);
      sclk = 1;
      cs_n = 1;
      cyc(H);
      sclk = 0;
      cyc(RDY_HOLD + 10);
      exp_last = v;
      compared += 2;
      if (got_b.size() != n0 + 1) begin mismatched++; $display("FAIL simul_count: got %0d want 1", got_b.size() - n0); end
      else if (got_b[n0] !== v) begin mismatched++; $display("FAIL simul_byte: got %h want %h", got_b[n0], v); end
      if (err_cnt != e0) begin mismatched++; $display("FAIL simul_err: got %0d want 0", err_cnt - e0); end
   endtask
   task automatic test_echo();
      logic [7:0] m, want;
`ifdef SPI_MISO_ECHO_EN
      want = 8'h12;
`else
      want = 8'h00;
`endif
      cs_lo();
      send_byte(8'h12, m);
      send_byte(8'h34, m);
      cs_up();
      compared += 3;
      if (m !== want) begin mismatched++; $display("FAIL echo_miso: got %h want %h", m, want); end
      if (miso !== 1'b0) begin mismatched++; $display("FAIL echo_idle_miso: got %b want 0", miso); end
      if (rx_byte !== 8'h34) begin mismatched++; $display("FAIL echo_rx_byte: got %h want 34", rx_byte); end
   endtask
   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] m, v;
      logic       t;
      int         n0, e0, nb, tail;
      for (int f = 0; f < 8; f++) begin
         H = $urandom_range(4, 6);
         nb = $urandom_range(0, 3);
         tail = $urandom_range(0, 7);
         exp_q.delete();
         n0 = got_b.size(); e0 = err_cnt;
         cs_lo();
         for (int i = 0; i < nb; i++) begin
            v = 8'($urandom);
            exp_q.push_back(v);
            send_byte(v, m);
         end
         for (int i = 0; i < tail; i++) send_bit(1'($urandom), t);
         cs_up();
         compared += 2;
         if (err_cnt - e0 != (tail != 0 ? 1 : 0)) begin mismatched++; $display("FAIL rand%0d_err: got %0d want %0d", f, err_cnt - e0, tail != 0); end
         if (got_b.size() - n0 != exp_q.size()) begin
            mismatched++; $display("FAIL rand%0d_count: got %0d want %0d", f, got_b.size() - n0, exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               compared++;
               if (got_b[n0 + i] !== exp_q[i]) begin mismatched++; $display("FAIL rand%0d_byte%0d: got %h want %h", f, i, got_b[n0 + i], exp_q[i]); end
            end
         end
         compared++;
         if (rx_byte !== exp_last) begin mismatched++; $display("FAIL rand%0d_hold: got %h want %h", f, rx_byte, exp_last); end
      end
   endtask
   initial begin
      test_reset();
      H = $urandom_range(4, 6);
      test_stream();
      test_cs_abort();
      test_timeout();
      test_simul();
      test_echo();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/spi_byte_receiver.md
# spi_byte_receiver

Synchronous-sampling SPI slave (mode 0, MSB first) that converts the external SPI pins into a stream of received bytes. It sits directly upstream of the RGBW frame dispatcher: each completed byte is presented on `rx_byte` together with a `rdy` level pulse long enough for the dispatcher's two-stage rising-edge detector. All pin inputs are oversampled in the `clk` domain; SCLK is never used as a clock.

## Interface
Parameters:
- `RDY_HOLD`, 4: cycles `rdy` stays high per byte; legal range 2..15.
- `TIMEOUT_CYCLES`, 1023: idle `clk` cycles with CS active and no SCLK edge before a partial byte is discarded; legal range 16..65535.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low.
- `sclk`  in  1  SPI clock, asynchronous to `clk`.
- `mosi`  in  1  SPI data in, asynchronous.
- `cs_n`  in  1  SPI chip select, active-low, asynchronous.
- `miso`  out  1  SPI data out; see Configuration.
- `rx_byte`  out  8  last completed byte.
- `rdy`  out  1  high for `RDY_HOLD` cycles after each completed byte.
- `frame_err`  out  1  one-cycle pulse when a byte is aborted (CS deasserted mid-byte, or timeout).

## Operation
- `sclk`, `mosi` and `cs_n` each pass through a 2-FF synchronizer. A third `sclk` flop provides edge detection: rise = sync 1 and prev 0; fall = sync 0 and prev 1.
- State machine:
  - IDLE: `cs_n` synced high; bit counter = 0. Synced `cs_n` low -> ACTIVE.
  - ACTIVE: on each SCLK rise, shift synced `mosi` into the LSB of an 8-bit shift register and increment the 3-bit bit counter.
    - When the counter wraps 7 -> 0, load `rx_byte` with {shift[6:0], mosi}, load the rdy hold counter with `RDY_HOLD`, and drive `rdy` high.
    - Synced `cs_n` high -> IDLE. If bit counter != 0, pulse `frame_err` and discard the partial byte.
    - Idle counter reaches `TIMEOUT_CYCLES` with bit counter != 0: pulse `frame_err`, clear bit counter and shift register, stay in ACTIVE.
- Idle counter: saturating, 16 bits. Cleared on any SCLK edge and in IDLE.
- `rx_byte` holds its value until the next completed byte. It never changes while `rdy` is high unless a new byte completes, which is a protocol violation: `rdy` is then reloaded and stays high.
- Bytes complete back-to-back within one CS frame with no limit; the bit counter wraps freely.
- Reset: all registers cleared. `rx_byte`=0x00, `rdy`=0, `frame_err`=0, `miso`=0, state IDLE, synchronizer flops = 0 for `sclk`/`mosi`, 1 for `cs_n`.
- Simultaneous CS deassert and 8th SCLK rise in the same cycle: the byte completes (`rdy` asserted), no `frame_err`, then IDLE.

## Timing
- Pin-to-detect latency: 2 `clk` cycles for the synchronizer plus 1 for edge detection. `rdy` rises 3 cycles after the `sclk` pin's 8th rising edge is first sampled high.
- `rdy` high for exactly `RDY_HOLD` cycles, then low for at least 1 cycle before the next byte completes, given the SCLK limit below.
- SCLK limit: each SCLK high and low phase ≥ 4 `clk` cycles. At 8-bit rate, a byte takes ≥ 64 cycles, so the `RDY_HOLD` ≤ 15 window closes before the next byte completes.
- `frame_err` asserted the cycle after the synced CS rise or the timeout hit; width 1 cycle.
- MOSI setup/hold relative to the SCLK pin edge: ≥ 3 `clk` cycles, so the synced `mosi` and `sclk` stay aligned.

## Configuration
- `SPI_MISO_ECHO_EN` defined:
  - `miso` transmits the previous `rx_byte` MSB first.
  - The TX shift register loads from `rx_byte` on the synced CS falling edge and on each byte completion.
  - `miso` updates on each detected SCLK fall, with bit 7 driven immediately after load.
  - `miso` = 0 in IDLE.
- `SPI_MISO_ECHO_EN` undefined: `miso` is tied to 0 and the TX shift register is not built.

## Test plan
- Reset mid-frame (`reset`=0 for 1 cycle during bit 4) -> all outputs 0, state IDLE. Next full byte 0xA5 is received correctly after CS is toggled.
- CS low, send 0x55 0x80 0x11 with SCLK half-period 4 clk -> three `rdy` pulses of 4 cycles each; `rx_byte` = 0x55, 0x80, 0x11, stable during each pulse. Feeding the dispatcher latches the intensity byte as 0x80.
- CS raised after 5 bits of 0xFF -> `frame_err` one-cycle pulse, no `rdy`, `rx_byte` unchanged. The next frame byte 0x3C is received correctly.
- CS held low, 3 bits sent, SCLK stopped for 1023+ cycles -> `frame_err` pulse. A fresh 8 bits of 0xC3 give `rx_byte`=0xC3.
- With `SPI_MISO_ECHO_EN`: send 0x12 then 0x34 in one frame -> `miso` shifts 0x12 during the second byte; after CS rise, `miso`=0. Without the macro, `miso` = 0 throughout.
